// File: rtl/lif_neuron_array_if.sv
// lif_neuron_array_if: request/result channel bundle for the LIF neuron engine
//   master (requester + result consumer) drives: in_valid, in_neuron_id, spike_in, weight,
//     v_threshold, decay_rate, out_ready
//   slave (engine) drives: in_ready, out_valid, out_neuron_id, spiked, potential_out
interface lif_neuron_array_if #(
    parameter int NUM_INPUTS  = 4,
    parameter int DATA_W      = 32,
    parameter int NUM_NEURONS = 8
);
    localparam int ID_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    logic                         in_valid;
    logic                         in_ready;
    logic [ID_W-1:0]              in_neuron_id;
    logic [NUM_INPUTS-1:0]        spike_in;
    logic [NUM_INPUTS*DATA_W-1:0] weight;
    logic [DATA_W-1:0]            v_threshold;
    logic [2:0]                   decay_rate;
    logic                         out_valid;
    logic                         out_ready;
    logic [ID_W-1:0]              out_neuron_id;
    logic                         spiked;
    logic [DATA_W-1:0]            potential_out;
    modport master (
        output in_valid, in_neuron_id, spike_in, weight, v_threshold, decay_rate, out_ready,
        input  in_ready, out_valid, out_neuron_id, spiked, potential_out
    );
    modport slave (
        input  in_valid, in_neuron_id, spike_in, weight, v_threshold, decay_rate, out_ready,
        output in_ready, out_valid, out_neuron_id, spiked, potential_out
    );
endinterface

// File: rtl/lif_neuron_array.sv
// lif_neuron_array: time-multiplexed leaky-integrate-and-fire engine for NUM_NEURONS neurons
//   CLK      : clock, rising edge
//   RESET_N  : asynchronous active-low reset
//   bus      : lif_neuron_array_if.slave (request in_* channel, result out_* channel)
//   Optional macro REFRACTORY_EN adds per-neuron refractory counters (REFRAC_STEPS updates).
module lif_neuron_array #(
    parameter int NUM_INPUTS   = 4,
    parameter int DATA_W       = 32,
    parameter int NUM_NEURONS  = 8,
    parameter int REFRAC_STEPS = 2
) (
    input logic              CLK,
    input logic              RESET_N,
    lif_neuron_array_if.slave bus
);
    localparam int ID_W  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int IX_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int ACC_W = DATA_W + $clog2(NUM_INPUTS) + 1;
    localparam int SUM_W = ACC_W + 1;
    localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic [ID_W:0] ID_LIM = (ID_W+1)'(NUM_NEURONS);

    if (REFRAC_STEPS < 1) begin : g_bad_refrac
        $error("REFRAC_STEPS must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, ACCUM, UPDATE, OUT} state_t;
    state_t state, state_nx;

    logic [ID_W-1:0]              cap_id;
    logic [NUM_INPUTS-1:0]        cap_spk;
    logic [NUM_INPUTS*DATA_W-1:0] cap_w;
    logic signed [DATA_W-1:0]     cap_thr;
    logic [2:0]                   cap_dec;
    logic [IX_W-1:0]              idx;
    logic signed [ACC_W-1:0]      acc;
    logic signed [DATA_W-1:0]     v_mem [NUM_NEURONS];

    logic                     last, id_ok, fire, refr;
    logic signed [DATA_W-1:0] w_cur, v_cur, v_dec, v_new;
    logic signed [SUM_W-1:0]  sum;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.in_valid ? ACCUM : IDLE;
            ACCUM:   state_nx = last ? UPDATE : ACCUM;
            UPDATE:  state_nx = OUT;
            OUT:     state_nx = bus.out_ready ? IDLE : OUT;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = state == IDLE;
        bus.out_valid = state == OUT;
    end

    assign last  = idx == IX_W'(NUM_INPUTS - 1);
    assign w_cur = cap_w[int'(idx)*DATA_W +: DATA_W];
    assign id_ok = {1'b0, cap_id} < ID_LIM;
    assign v_cur = v_mem[cap_id];
    // a zero shift would otherwise leak the whole potential away
    assign v_dec = (cap_dec == 3'd0) ? v_cur : v_cur - (v_cur >>> cap_dec);
    assign sum   = SUM_W'(v_dec) + SUM_W'(acc);
    assign v_new = (sum > SAT_MAX) ? SAT_MAX[DATA_W-1:0] : (sum < SAT_MIN) ? SAT_MIN[DATA_W-1:0] : sum[DATA_W-1:0];
    assign fire  = v_new >= cap_thr;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cap_id  <= '0;
            cap_spk <= '0;
            cap_w   <= '0;
            cap_thr <= '0;
            cap_dec <= '0;
            acc     <= '0;
            idx     <= '0;
        end else if (state == IDLE && bus.in_valid) begin
            cap_id  <= bus.in_neuron_id;
            cap_spk <= bus.spike_in;
            cap_w   <= bus.weight;
            cap_thr <= bus.v_threshold;
            cap_dec <= bus.decay_rate;
            acc     <= '0;
            idx     <= '0;
        end else if (state == ACCUM) begin
            acc <= acc + (cap_spk[idx] ? ACC_W'(w_cur) : '0);
            idx <= idx + 1'b1;
        end
    end

    // result registers and potential storage are written together on the UPDATE edge
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            bus.out_neuron_id <= '0;
            bus.spiked        <= 1'b0;
            bus.potential_out <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) v_mem[i] <= '0;
        end else if (state == UPDATE) begin
            bus.out_neuron_id <= cap_id;
            bus.spiked        <= id_ok && !refr && fire;
            bus.potential_out <= (id_ok && !refr) ? v_new : '0;
            if (id_ok) v_mem[cap_id] <= (refr || fire) ? '0 : v_new;
        end
    end

`ifdef REFRACTORY_EN
    localparam int RC_W = $clog2(REFRAC_STEPS + 1);
    logic [RC_W-1:0] rc [NUM_NEURONS];
    assign refr = rc[cap_id] != '0;
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) for (int i = 0; i < NUM_NEURONS; i++) rc[i] <= '0;
        else if (state == UPDATE && id_ok) rc[cap_id] <= refr ? rc[cap_id] - 1'b1 : fire ? RC_W'(REFRAC_STEPS) : '0;
    end
`else
    assign refr = 1'b0;
`endif
endmodule

// File: tb/tb_lif_neuron_array.sv
// tb_lif_neuron_array: scoreboard bench for lif_neuron_array (directed plan vectors plus model-checked random traffic)
module tb_lif_neuron_array;
    localparam int NI = 4, DW = 32, NN = 8, RS = 2;
    localparam longint MAXV = 64'sd2147483647, MINV = -64'sd2147483648;

    logic CLK = 1'b0, RESET_N = 1'b0;
    always #5 CLK = ~CLK;

    lif_neuron_array_if #(.NUM_INPUTS(NI), .DATA_W(DW), .NUM_NEURONS(NN)) bus ();
    lif_neuron_array #(.NUM_INPUTS(NI), .DATA_W(DW), .NUM_NEURONS(NN), .REFRAC_STEPS(RS)) dut (
        .CLK(CLK),
        .RESET_N(RESET_N),
        .bus(bus)
    );

    typedef struct {
        logic [2:0] id;
        logic       spk;
        longint     pot;
    } exp_t;
    exp_t   sbq[$];
    longint mv[NN];
    int     mr[NN];
    int     n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic void model(input int id, input logic [NI-1:0] s, input logic [NI*DW-1:0] w,
                                  input longint thr, input int d, output logic spk, output longint pot);
        longint acc = 0, v, nv;
`ifdef REFRACTORY_EN
        if (mr[id] != 0) begin
            mr[id]--;
            mv[id] = 0;
            spk = 1'b0;
            pot = 0;
            return;
        end
`endif
        for (int i = 0; i < NI; i++) if (s[i]) acc += longint'($signed(w[i*DW +: DW]));
        v  = mv[id];
        nv = (d == 0 ? v : v - (v >>> d)) + acc;
        nv = nv > MAXV ? MAXV : nv < MINV ? MINV : nv;
        spk = nv >= thr;
        pot = nv;
        mv[id] = spk ? 0 : nv;
`ifdef REFRACTORY_EN
        if (spk) mr[id] = RS;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NN; i++) begin
            mv[i] = 0;
            mr[i] = 0;
        end
    endtask

    // drives a request at a negedge, returns at the negedge right after the accepting edge
    task automatic issue(input int id, input logic [NI-1:0] s, input logic [NI*DW-1:0] w, input longint thr,
                         input int d, input bit use_mdl, input logic exp_spk, input longint exp_pot);
        exp_t   e;
        logic   ms;
        longint mp;
        int     t = 0;
        model(id, s, w, thr, d, ms, mp);
        e.id  = 3'(id);
        e.spk = use_mdl ? ms : exp_spk;
        e.pot = use_mdl ? mp : exp_pot;
        bus.in_neuron_id = 3'(id);
        bus.spike_in     = s;
        bus.weight       = w;
        bus.v_threshold  = thr[DW-1:0];
        bus.decay_rate   = 3'(d);
        bus.in_valid     = 1'b1;
        while (!bus.in_ready && t < 40) begin
            @(negedge CLK);
            t++;
        end
        chk("accept_ready", bus.in_ready, 1);
        sbq.push_back(e);
        @(posedge CLK);
        @(negedge CLK);
        bus.in_valid     = 1'b0;
        bus.spike_in     = 4'($urandom);
        bus.weight       = {$urandom, $urandom, $urandom, $urandom};
        bus.v_threshold  = $urandom;
        bus.decay_rate   = 3'($urandom);
        bus.in_neuron_id = 3'($urandom);
    endtask

    task automatic collect();
        exp_t e;
        int   lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge CLK);
            lat++;
        end
        chk("latency", lat, NI + 1);
        if (sbq.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
            return;
        end
        e = sbq.pop_front();
        chk("out_neuron_id", bus.out_neuron_id, e.id);
        chk("spiked", bus.spiked, e.spk);
        chk("potential_out", longint'($signed(bus.potential_out)), e.pot);
        if (bus.out_ready) begin
            @(posedge CLK);
            @(negedge CLK);
            chk("in_ready_after_out", bus.in_ready, 1);
            chk("out_valid_after_out", bus.out_valid, 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [NI*DW-1:0] w;
        logic [NI-1:0]    s;
        int               x;
        model_reset();
        bus.in_valid     = 1'b0;
        bus.out_ready    = 1'b1;
        bus.in_neuron_id = '0;
        bus.spike_in     = '0;
        bus.weight       = '0;
        bus.v_threshold  = '0;
        bus.decay_rate   = '0;
        repeat (3) @(negedge CLK);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_id", bus.out_neuron_id, 0);
        chk("rst_spiked", bus.spiked, 0);
        chk("rst_potential", bus.potential_out, 0);
        RESET_N = 1'b1;
        @(negedge CLK);

        w = {32'd0, 32'd0, 32'd50, 32'd40};
        issue(0, 4'b0011, w, 78, 4, 0, 1'b1, 90);
        collect();
        issue(0, 4'b0000, w, 78, 4, 0, 1'b0, 0);
        collect();

        w = {32'd0, 32'd0, 32'd0, -32'sd100};
        issue(2, 4'b0001, w, 78, 4, 0, 1'b0, -100);
        collect();
        issue(2, 4'b0000, w, 78, 1, 0, 1'b0, -50);
        collect();
        issue(2, 4'b0000, w, 78, 0, 0, 1'b0, -50);
        collect();

        w = {4{32'h7FFFFFFF}};
        issue(5, 4'b1111, w, 32'h7FFFFFFF, 2, 0, 1'b1, MAXV);
        collect();

        bus.out_ready = 1'b0;
        issue(3, 4'b0001, {96'd0, 32'd500}, 1000, 0, 0, 1'b0, 500);
        collect();
        bus.in_neuron_id = 3'd4;
        bus.spike_in     = 4'b0001;
        bus.weight       = {96'd0, 32'd700};
        bus.v_threshold  = 32'd1000;
        bus.decay_rate   = 3'd0;
        bus.in_valid     = 1'b1;
        repeat (10) begin
            @(negedge CLK);
            chk("stall_out_valid", bus.out_valid, 1);
            chk("stall_out_id", bus.out_neuron_id, 3);
            chk("stall_potential", longint'($signed(bus.potential_out)), 500);
            chk("stall_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("stall_release_ready", bus.in_ready, 1);
        issue(4, 4'b0001, {96'd0, 32'd700}, 1000, 0, 0, 1'b0, 700);
        collect();
        issue(3, 4'b0000, {96'd0, 32'd1}, 1000, 0, 0, 1'b0, 500);
        collect();

        issue(0, 4'b0001, {96'd0, 32'd30}, 1000, 0, 0, 1'b0, 30);
        collect();
        issue(0, 4'b0001, {96'd0, 32'd30}, 1000, 0, 0, 1'b0, 60);
        @(negedge CLK);
        RESET_N = 1'b0;
        repeat (2) @(negedge CLK);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        RESET_N = 1'b1;
        sbq.delete();
        model_reset();
        repeat (8) @(negedge CLK);
        chk("postrst_out_valid", bus.out_valid, 0);
        chk("postrst_in_ready", bus.in_ready, 1);
        issue(0, 4'b0001, {96'd0, 32'd7}, 1000, 0, 0, 1'b0, 7);
        collect();

`ifdef REFRACTORY_EN
        w = {96'd0, 32'd1000};
        issue(6, 4'b0001, w, 500, 0, 0, 1'b1, 1000);
        collect();
        issue(6, 4'b0001, w, 500, 0, 0, 1'b0, 0);
        collect();
        issue(6, 4'b0001, w, 500, 0, 0, 1'b0, 0);
        collect();
        issue(6, 4'b0001, w, 500, 0, 0, 1'b1, 1000);
        collect();
`endif

        for (int k = 0; k < 24; k++) begin
            s = 4'($urandom);
            for (int i = 0; i < NI; i++) begin
                x = int'($urandom_range(0, 4000)) - 2000;
                w[i*DW +: DW] = x;
            end
            if (k % 6 == 5) begin
                s = 4'b1111;
                w = {4{32'h80000001}};
            end
            x = int'($urandom_range(0, 3000)) - 500;
            issue(int'($urandom_range(0, NN - 1)), s, w, x, int'($urandom_range(0, 7)), 1, 1'b0, 0);
            collect();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
